aes_rcon_seq: RTL and testbench

Sequential AES key-schedule word sequencer and round-constant generator. It replaces the fixed 10-entry Rcon lookup with a GF(2^8) iterator. It supports all three key lengths (128/192/256) and, optionally, reverse-order generation for on-the-fly decryption key expansion. It sits between the key-expansion controller and the word datapath. For each expanded word index it emits the Rcon byte and the RotWord/SubWord control flags over a valid/ready handshake.

---
 rtl/aes_rcon_seq.sv | 201 ++++++++++++++++++++
 tb/tb_aes_rcon_seq.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_rcon_seq.sv
// AES key-schedule word sequencer: emits word index, Rcon (GF(2^8) iterated) and RotWord/SubWord flags.
// Reverse-order generation for on-the-fly decryption expansion is compiled in with AES_RCON_REV_EN.
module aes_rcon_seq #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] POLY  = 8'h1B
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic             dir,
  input  logic             ready,
  output logic             valid,
  output logic [5:0]       word_idx,
  output logic [WIDTH-1:0] rcon,
  output logic             rot_sub,
  output logic             sub_only,
  output logic             last,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIN = 2'd2} state_t;

  function automatic logic [WIDTH-1:0] xtime(input logic [WIDTH-1:0] a);
    return {a[WIDTH-2:0], 1'b0} ^ (a[WIDTH-1] ? POLY : '0);
  endfunction

  state_t           state_q;
  logic             valid_q, rot_sub_q, sub_only_q, last_q, busy_q, done_q;
  logic [5:0]       idx_q, end_q;
  logic [WIDTH-1:0] rcon_q, rc_q;
  logic [2:0]       pos_q, nkm1_q;
  logic             nk8_q;

  logic [1:0]       mode_eff;
  logic [2:0]       s_nkm1;
  logic             s_nk8;
  logic [5:0]       s_first, s_final;
  logic [5:0]       idx_d, end_d;
  logic [2:0]       pos_d, nkm1_d;
  logic             nk8_d;
  logic [WIDTH-1:0] rc_d, rcon_d;
  logic             rot_sub_d, sub_only_d, last_d, load;

`ifdef AES_RCON_REV_EN
  function automatic logic [WIDTH-1:0] inv_xtime(input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] bx;
    bx = b ^ POLY;
    return b[0] ? {1'b1, bx[WIDTH-1:1]} : {1'b0, b[WIDTH-1:1]};
  endfunction

  function automatic logic [WIDTH-1:0] rc_after(input int n);
    logic [WIDTH-1:0] r;
    r = WIDTH'(1);
    for (int k = 0; k < n; k++) r = xtime(r);
    return r;
  endfunction

  localparam bit STD_POLY = (WIDTH == 8) && (POLY == WIDTH'(8'h1B));
  localparam logic [WIDTH-1:0] RC_REV128 = STD_POLY ? WIDTH'(8'h36) : rc_after(9);
  localparam logic [WIDTH-1:0] RC_REV192 = STD_POLY ? WIDTH'(8'h80) : rc_after(7);
  localparam logic [WIDTH-1:0] RC_REV256 = STD_POLY ? WIDTH'(8'h40) : rc_after(6);

  logic             rev_q, rev_d;
  logic [WIDTH-1:0] s_rc_rev;
`else
  logic unused_dir;
  assign unused_dir = dir;
`endif

  always_comb begin
    mode_eff = (mode == 2'b11) ? 2'b00 : mode;
    s_nkm1   = 3'd3;
    s_nk8    = 1'b0;
    s_first  = 6'd4;
    s_final  = 6'd43;
    case (mode_eff)
      2'b01:   begin s_nkm1 = 3'd5; s_first = 6'd6; s_final = 6'd51; end
      2'b10:   begin s_nkm1 = 3'd7; s_nk8 = 1'b1; s_first = 6'd8; s_final = 6'd59; end
      default: ;
    endcase
    nkm1_d = nkm1_q;
    nk8_d  = nk8_q;
    end_d  = end_q;
    idx_d  = idx_q;
    pos_d  = pos_q;
    rc_d   = rc_q;
`ifdef AES_RCON_REV_EN
    rev_d    = (state_q == IDLE) ? dir : rev_q;
    s_rc_rev = RC_REV128;
    case (mode_eff)
      2'b01:   s_rc_rev = RC_REV192;
      2'b10:   s_rc_rev = RC_REV256;
      default: ;
    endcase
`endif
    if (state_q == IDLE) begin
      nkm1_d = s_nkm1;
      nk8_d  = s_nk8;
`ifdef AES_RCON_REV_EN
      // Final index 4(Nr+1)-1 is 3 mod Nk for every key length.
      if (rev_d) begin
        idx_d = s_final; end_d = s_first; pos_d = 3'd3; rc_d = s_rc_rev;
      end else
`endif
      begin
        idx_d = s_first; end_d = s_final; pos_d = 3'd0; rc_d = WIDTH'(1);
      end
    end else begin
`ifdef AES_RCON_REV_EN
      if (rev_d) begin
        idx_d = idx_q - 6'd1;
        pos_d = (pos_q == 3'd0) ? nkm1_q : pos_q - 3'd1;
        rc_d  = rot_sub_q ? inv_xtime(rc_q) : rc_q;
      end else
`endif
      begin
        idx_d = idx_q + 6'd1;
        pos_d = (pos_q == nkm1_q) ? 3'd0 : pos_q + 3'd1;
        rc_d  = rot_sub_q ? xtime(rc_q) : rc_q;
      end
    end
    rot_sub_d  = (pos_d == 3'd0);
    sub_only_d = nk8_d && (pos_d == 3'd4);
    last_d     = (idx_d == end_d);
    rcon_d     = rot_sub_d ? rc_d : '0;
    load       = ((state_q == IDLE) && start) || ((state_q == RUN) && ready && !last_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      valid_q    <= 1'b0;
      rot_sub_q  <= 1'b0;
      sub_only_q <= 1'b0;
      last_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      idx_q      <= '0;
      end_q      <= '0;
      rcon_q     <= '0;
      rc_q       <= '0;
      pos_q      <= '0;
      nkm1_q     <= '0;
      nk8_q      <= 1'b0;
`ifdef AES_RCON_REV_EN
      rev_q      <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: if (start) begin
          state_q <= RUN;
          valid_q <= 1'b1;
          busy_q  <= 1'b1;
        end
        RUN: if (ready && last_q) begin
          state_q    <= FIN;
          valid_q    <= 1'b0;
          done_q     <= 1'b1;
          rot_sub_q  <= 1'b0;
          sub_only_q <= 1'b0;
          last_q     <= 1'b0;
          rcon_q     <= '0;
        end
        FIN: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
      // Shared by the initial load and every non-final handshake.
      if (load) begin
        idx_q      <= idx_d;
        end_q      <= end_d;
        pos_q      <= pos_d;
        rc_q       <= rc_d;
        nkm1_q     <= nkm1_d;
        nk8_q      <= nk8_d;
        rot_sub_q  <= rot_sub_d;
        sub_only_q <= sub_only_d;
        last_q     <= last_d;
        rcon_q     <= rcon_d;
`ifdef AES_RCON_REV_EN
        rev_q      <= rev_d;
`endif
      end
    end
  end

  assign valid    = valid_q;
  assign word_idx = idx_q;
  assign rcon     = rcon_q;
  assign rot_sub  = rot_sub_q;
  assign sub_only = sub_only_q;
  assign last     = last_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_aes_rcon_seq.sv
// Directed bench for aes_rcon_seq: forward sequences for all key lengths, backpressure, reset, ignored starts.
module tb_aes_rcon_seq;
  logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, dir = 1'b0, ready = 1'b0;
  logic [1:0] mode = 2'b00;
  logic       valid, rot_sub, sub_only, last, busy, done;
  logic [5:0] word_idx;
  logic [7:0] rcon;
  int n_checks = 0, n_fail = 0;

  aes_rcon_seq #(.WIDTH(8), .POLY(8'h1B)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .dir(dir), .ready(ready),
    .valid(valid), .word_idx(word_idx), .rcon(rcon), .rot_sub(rot_sub),
    .sub_only(sub_only), .last(last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [5:0] c_idx [64];
  logic [7:0] c_rcon [64];
  logic       c_rot [64], c_sub [64], c_last [64];
  int   c_n, c_unstable, c_bubble;
  logic c_v0, c_b0, c_to, c_done1, c_valid1, c_busy1, c_done2, c_busy2;

  function automatic logic [7:0] rc_tbl(input int k);
    case (k)
      0: return 8'h01; 1: return 8'h02; 2: return 8'h04; 3: return 8'h08; 4: return 8'h10;
      5: return 8'h20; 6: return 8'h40; 7: return 8'h80; 8: return 8'h1B; 9: return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // {rot_sub, sub_only, last, rcon} expected for word idx of a key with Nk words
  function automatic logic [10:0] exp_word(input int nk, input int idx, input logic lst);
    logic r, s;
    logic [7:0] rc;
    r  = (idx % nk == 0);
    s  = (nk == 8) && (idx % 8 == 4);
    rc = r ? rc_tbl(idx / nk - 1) : 8'h00;
    return {r, s, lst, rc};
  endfunction

  task automatic capture(input logic [1:0] m, input logic d, input int pct);
    int cyc;
    logic hs_last, stalled;
    logic [17:0] snap;
    for (int k = 0; k < 64; k++) begin
      c_idx[k] = '0; c_rcon[k] = '0; c_rot[k] = 0; c_sub[k] = 0; c_last[k] = 0;
    end
    c_n = 0; c_unstable = 0; c_bubble = 0;
    mode = m; dir = d; start = 1'b1; ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    c_v0 = valid; c_b0 = busy;
    cyc = 0; hs_last = 0; stalled = 0; snap = '0;
    while (!hs_last && cyc < 400) begin
      if (stalled && {word_idx, rcon, rot_sub, sub_only, last, valid} !== snap) c_unstable++;
      if (!valid) c_bubble++;
      ready = (pct >= 100) ? 1'b1 : (int'($urandom_range(99)) < pct);
      if (valid && ready) begin
        if (c_n < 64) begin
          c_idx[c_n] = word_idx; c_rcon[c_n] = rcon; c_rot[c_n] = rot_sub;
          c_sub[c_n] = sub_only; c_last[c_n] = last;
        end
        c_n++;
        hs_last = last;
        stalled = 0;
      end else begin
        stalled = valid;
        snap = {word_idx, rcon, rot_sub, sub_only, last, valid};
      end
      @(posedge clk); #1;
      cyc++;
    end
    c_to = !hs_last;
    c_done1 = done; c_valid1 = valid; c_busy1 = busy;
    ready = 1'b0;
    @(posedge clk); #1;
    c_done2 = done; c_busy2 = busy;
  endtask

  task automatic drain(output logic timed_out);
    int cyc;
    ready = 1'b1; cyc = 0;
    while ((busy || valid) && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    timed_out = busy || valid;
    ready = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if ({valid, word_idx, rcon, rot_sub, sub_only, last, busy, done} !== 20'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h, required 0", {valid, word_idx, rcon, rot_sub, sub_only, last, busy, done});
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({valid, busy, done} !== 3'b000) begin
      n_fail++;
      $display("FAIL idle_after_reset: valid/busy/done=%b, required 000", {valid, busy, done});
    end
  endtask

  task automatic test_aes128_fwd();
    logic [10:0] e, a;
    capture(2'b00, 1'b0, 100);
    n_checks++;
    if ({c_v0, c_b0} !== 2'b11) begin
      n_fail++; $display("FAIL a128_start_latency: valid/busy=%b, required 11", {c_v0, c_b0});
    end
    n_checks++;
    if (c_to || c_n != 40) begin
      n_fail++; $display("FAIL a128_count: words=%0d timeout=%0b, required 40", c_n, c_to);
    end
    for (int k = 0; k < 40; k++) begin
      e = exp_word(4, 4 + k, k == 39);
      a = {c_rot[k], c_sub[k], c_last[k], c_rcon[k]};
      n_checks++;
      if (c_idx[k] !== 6'(4 + k) || a !== e) begin
        n_fail++;
        $display("FAIL a128_word%0d: idx=%0d rot/sub/last/rcon=%h, required idx=%0d %h", k, c_idx[k], a, 4 + k, e);
      end
    end
    n_checks++;
    if ({c_done1, c_valid1, c_busy1, c_done2, c_busy2} !== 5'b10100) begin
      n_fail++;
      $display("FAIL a128_completion: done/valid/busy N+1, done/busy N+2 = %b, required 10100",
               {c_done1, c_valid1, c_busy1, c_done2, c_busy2});
    end
    n_checks++;
    if (c_bubble != 0) begin
      n_fail++; $display("FAIL a128_bubbles: %0d, required 0", c_bubble);
    end
  endtask

  task automatic test_aes256_fwd();
    logic [10:0] e, a;
    capture(2'b10, 1'b0, 100);
    n_checks++;
    if (c_to || c_n != 52) begin
      n_fail++; $display("FAIL a256_count: words=%0d timeout=%0b, required 52", c_n, c_to);
    end
    for (int k = 0; k < 52; k++) begin
      e = exp_word(8, 8 + k, k == 51);
      a = {c_rot[k], c_sub[k], c_last[k], c_rcon[k]};
      n_checks++;
      if (c_idx[k] !== 6'(8 + k) || a !== e) begin
        n_fail++;
        $display("FAIL a256_word%0d: idx=%0d rot/sub/last/rcon=%h, required idx=%0d %h", k, c_idx[k], a, 8 + k, e);
      end
    end
  endtask

  task automatic test_aes192_backpressure();
    logic [10:0] e, a;
    capture(2'b01, 1'b0, 55);
    n_checks++;
    if (c_to || c_n != 46) begin
      n_fail++; $display("FAIL a192_count: words=%0d timeout=%0b, required 46", c_n, c_to);
    end
    n_checks++;
    if (c_unstable != 0 || c_bubble != 0) begin
      n_fail++; $display("FAIL a192_stall: unstable=%0d bubbles=%0d, required 0/0", c_unstable, c_bubble);
    end
    for (int k = 0; k < 46; k++) begin
      e = exp_word(6, 6 + k, k == 45);
      a = {c_rot[k], c_sub[k], c_last[k], c_rcon[k]};
      n_checks++;
      if (c_idx[k] !== 6'(6 + k) || a !== e) begin
        n_fail++;
        $display("FAIL a192_word%0d: idx=%0d rot/sub/last/rcon=%h, required idx=%0d %h", k, c_idx[k], a, 6 + k, e);
      end
    end
  endtask

  task automatic test_reset_midrun();
    int cyc;
    logic to;
    mode = 2'b00; dir = 1'b0; ready = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; cyc = 0;
    while (word_idx !== 6'd20 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    n_checks++;
    if (word_idx !== 6'd20) begin
      n_fail++; $display("FAIL midrun_reach20: idx=%0d, required 20", word_idx);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({valid, word_idx, rcon, rot_sub, sub_only, last, busy, done} !== 20'h0) begin
      n_fail++;
      $display("FAIL midrun_reset: got %h, required 0", {valid, word_idx, rcon, rot_sub, sub_only, last, busy, done});
    end
    #1 rst_n = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_checks++;
    if ({valid, word_idx, rot_sub, rcon} !== {1'b1, 6'd4, 1'b1, 8'h01}) begin
      n_fail++;
      $display("FAIL midrun_restart: valid=%b idx=%0d rot=%b rcon=%h, required 1 4 1 01", valid, word_idx, rot_sub, rcon);
    end
    drain(to);
    n_checks++;
    if (to) begin
      n_fail++; $display("FAIL midrun_drain: timeout, required completion");
    end
  endtask

  task automatic test_start_ignored();
    int cyc, cnt, bad, expi;
    logic seen_last, to;
    mode = 2'b00; dir = 1'b0; ready = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0; cnt = 0; bad = 0; expi = 4; seen_last = 0;
    while (!seen_last && cyc < 200) begin
      if (cyc == 2) begin start = 1'b1; mode = 2'b10; dir = 1'b1; end
      if (cyc == 3) start = 1'b0;
      if (cyc == 5) mode = 2'b01;
      if (valid) begin
        if ({word_idx, rot_sub, sub_only, last, rcon} !== {6'(expi), exp_word(4, expi, expi == 43)}) bad++;
        cnt++; expi++; seen_last = last;
      end else bad++;
      @(posedge clk); #1;
      cyc++;
    end
    n_checks++;
    if (bad != 0 || cnt != 40) begin
      n_fail++; $display("FAIL ignore_run: words=%0d bad=%0d, required 40 and 0", cnt, bad);
    end
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++; $display("FAIL ignore_fin_done: done=%b, required 1", done);
    end
    start = 1'b1; mode = 2'b10;
    @(posedge clk); #1;
    n_checks++;
    if ({valid, busy, done} !== 3'b000) begin
      n_fail++; $display("FAIL ignore_fin_start: valid/busy/done=%b, required 000", {valid, busy, done});
    end
    mode = 2'b00;
    @(posedge clk); #1;
    start = 1'b0;
    n_checks++;
    if ({valid, busy, word_idx, rot_sub, rcon} !== {1'b1, 1'b1, 6'd4, 1'b1, 8'h01}) begin
      n_fail++;
      $display("FAIL accept_after_done: valid=%b busy=%b idx=%0d rot=%b rcon=%h, required 1 1 4 1 01",
               valid, busy, word_idx, rot_sub, rcon);
    end
    drain(to);
    n_checks++;
    if (to) begin
      n_fail++; $display("FAIL ignore_drain: timeout, required completion");
    end
  endtask

`ifdef AES_RCON_REV_EN
  task automatic test_aes128_rev();
    logic [10:0] e, a;
    capture(2'b00, 1'b1, 100);
    n_checks++;
    if (c_to || c_n != 40) begin
      n_fail++; $display("FAIL rev128_count: words=%0d timeout=%0b, required 40", c_n, c_to);
    end
    for (int k = 0; k < 40; k++) begin
      e = exp_word(4, 43 - k, k == 39);
      a = {c_rot[k], c_sub[k], c_last[k], c_rcon[k]};
      n_checks++;
      if (c_idx[k] !== 6'(43 - k) || a !== e) begin
        n_fail++;
        $display("FAIL rev128_word%0d: idx=%0d rot/sub/last/rcon=%h, required idx=%0d %h", k, c_idx[k], a, 43 - k, e);
      end
    end
  endtask
`else
  task automatic test_dir_ignored();
    capture(2'b00, 1'b1, 100);
    n_checks++;
    if (c_to || c_n != 40 || c_idx[0] !== 6'd4 || c_idx[39] !== 6'd43 || c_last[39] !== 1'b1) begin
      n_fail++;
      $display("FAIL dir_ignored: words=%0d first=%0d last_idx=%0d, required 40 4 43", c_n, c_idx[0], c_idx[39]);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_aes128_fwd();
    test_aes256_fwd();
    test_aes192_backpressure();
    test_reset_midrun();
    test_start_ignored();
`ifdef AES_RCON_REV_EN
    test_aes128_rev();
`else
    test_dir_ignored();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
